config_frame_sequencer: RTL and testbench
=========================================

Name: config_frame_sequencer

Overview:
- Fabric-level configuration controller. It takes a 32-bit bitstream word stream over a valid/ready handshake and drives the flattened FrameData / FrameStrobe buses feeding every tile's config-memory frame latches.
- Handles sync detection, frame addressing and multi-row data assembly.
- Generates a glitch-free strobe timing: data is set up before the strobe, strobe lasts one cycle, data is held after it.
- Sits between the bitstream source (UART/SPI/host port) and the fabric array.

Parameters:
- NumberOfRows, 4, tile rows; FrameData carries one 32-bit word per row.
- NumberOfCols, 4, tile columns.
- MaxFramesPerCol, 20, frames per column; must be ≤ 256.
- FrameBitsPerRow, 32, bits per row per frame; fixed at 32 (must equal the stream word width).
- SyncWord, 32'hFAB0_FAB1, word that enters the synced state.

Ports:
- CLK  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- s_data  in  32  bitstream word
- s_valid  in  1  s_data valid
- s_ready  out  1  word accepted when s_valid & s_ready at rising CLK
- FrameData  out  FrameBitsPerRow*NumberOfRows  row r occupies bits [r*32 +: 32]
- FrameStrobe  out  MaxFramesPerCol*NumberOfCols  bit col*MaxFramesPerCol+frame; at most one bit high
- synced  out  1  high in every state except DESYNC
- error  out  1  sticky address-range error
- frames_written  out  16  count of strobes issued; saturates at 16'hFFFF

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=DESYNC; FrameData=0; FrameStrobe=0; s_ready=0 during reset.
  - error=0; frames_written=0; internal row counter=0; latched col/frame=0.
  - Reset mid-operation aborts immediately; the strobe drops in the same instant.
- All outputs are registered.
- States:
  - DESYNC: s_ready=1. Accepted word == SyncWord -> ADDR. Any other word is discarded.
  - ADDR: s_ready=1. Decode the accepted word:
    - [31:28]==4'hF: desync -> DESYNC.
    - word == SyncWord: ignored, stay in ADDR.
    - Otherwise latch col=[23:16] and frame=[7:0], clear the row counter, go to DATA.
  - DATA: s_ready=1. Each accepted word is written to FrameData row[row counter], then the row counter increments.
    - The word accepted when the counter reaches NumberOfRows-1 goes to SETUP.
    - FrameData rows not yet rewritten keep their previous values.
  - SETUP: s_ready=0. FrameData is stable; FrameStrobe=0. Lasts one cycle, then STROBE.
  - STROBE: s_ready=0. Lasts one cycle.
    - If col<NumberOfCols and frame<MaxFramesPerCol: FrameStrobe bit col*MaxFramesPerCol+frame=1 and frames_written increments, saturating.
    - Otherwise FrameStrobe stays 0 and error is set to 1.
    - Next state is HOLD.
  - HOLD: s_ready=0. FrameStrobe=0 and FrameData unchanged. Lasts one cycle, then ADDR.
- Latency: from acceptance of the last data word, the strobe is high exactly 2 cycles later, for exactly 1 cycle. The earliest next address word is accepted 4 cycles after the last data word.
- FrameData changes only on DATA acceptances, never in SETUP, STROBE or HOLD.
- A desync word is only recognised in ADDR. In DATA, every word (including SyncWord or 4'hF-prefixed words) is treated as data.
- s_valid low stalls any accepting state indefinitely with no output change.
- error clears only on reset. A re-sync does not clear error or frames_written.
- synced follows the registered state.

Test Plan:
- Reset release, s_valid=0 -> all outputs 0, s_ready=1, synced=0; stream {0x12345678, SyncWord} -> synced=1 only after the second word, no strobe.
- NumberOfRows=4: SyncWord, addr 0x0002_0005, data A0..A3 -> FrameData={A3,A2,A1,A0}.
  - FrameStrobe bit 2*20+5=45 high for exactly one cycle, 2 cycles after A3 is accepted.
  - s_ready low for 3 cycles; frames_written=1.
- Back-to-back frames with s_valid held high: frames (col0,fr0) then (col3,fr19) -> strobes on bits 0 then 79.
  - FrameData stable throughout SETUP/STROBE/HOLD; frames_written=2.
- Out-of-range addr 0x0004_0000 (col=4), then addr 0x0000_0014 (frame=20) -> 4 data words each consumed, no strobe bit ever high, error=1, frames_written unchanged.
- Desync 0xF000_0000 in ADDR -> synced=0 the next cycle; a further addr/data stream is ignored until SyncWord. In DATA, 0xF000_0000 is stored as data.
- Assert resetn=0 during STROBE -> FrameStrobe=0 immediately; after release state=DESYNC, FrameData=0, error=0, frames_written=0.

Source files
------------

// File: rtl/config_frame_sequencer.sv
// config_frame_sequencer
//   Configuration controller for the fabric. It consumes a 32-bit bitstream
//   word stream over a valid/ready handshake, finds the sync word, decodes
//   frame addresses and assembles one 32-bit word per tile row. It then
//   pulses a single frame-strobe bit. Data is set up one cycle before the
//   strobe, the strobe lasts one cycle, and data is held for one cycle after.
//
// Ports
//   CLK, resetn      clock, asynchronous active-low reset
//   s_data/s_valid   bitstream word and its valid flag
//   s_ready          word accepted on s_valid & s_ready at rising CLK
//   FrameData        row r on bits [r*32 +: 32]
//   FrameStrobe      bit col*MaxFramesPerCol+frame; at most one bit high
//   synced           high in every state except DESYNC
//   error            sticky: a frame address was out of range
//   frames_written   strobes issued, saturating at 16'hFFFF

// One row of the frame data register; written only while assembling a frame.
module config_frame_row #(
  parameter int Width = 32
) (
  input  logic             CLK,
  input  logic             resetn,
  input  logic             wrEn,
  input  logic [Width-1:0] wrData,
  output logic [Width-1:0] rowData
);
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn)   rowData <= '0;
    else if (wrEn) rowData <= wrData;
  end
endmodule

module config_frame_sequencer #(
  parameter int          NumberOfRows    = 4,
  parameter int          NumberOfCols    = 4,
  parameter int          MaxFramesPerCol = 20,
  parameter int          FrameBitsPerRow = 32,
  parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
  input  logic                                    CLK,
  input  logic                                    resetn,
  input  logic [31:0]                             s_data,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  output logic [FrameBitsPerRow*NumberOfRows-1:0] FrameData,
  output logic [MaxFramesPerCol*NumberOfCols-1:0] FrameStrobe,
  output logic                                    synced,
  output logic                                    error,
  output logic [15:0]                             frames_written
);
  localparam int RowW       = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
  localparam int NumStrobes = MaxFramesPerCol * NumberOfCols;

  typedef enum logic [2:0] {DESYNC, ADDR, DATA, SETUP, STROBE, HOLD} state_t;

  state_t                  state, stateNext;
  logic                    accept, lastRow, inRange;
  logic [RowW-1:0]         rowCnt;
  logic [7:0]              colQ, frameQ;
  logic [NumberOfRows-1:0] rowWe;
  logic [NumStrobes-1:0]   strobeNext;

  assign accept  = s_valid & s_ready;
  assign lastRow = (int'(rowCnt) == NumberOfRows - 1);
  assign inRange = (int'(colQ) < NumberOfCols) && (int'(frameQ) < MaxFramesPerCol);
  assign synced  = (state != DESYNC);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) state <= DESYNC;
    else         state <= stateNext;
  end

  // SyncWord itself has a 4'hF prefix, so it is tested before the desync
  // prefix; otherwise a repeated sync word in ADDR would drop sync.
  always_comb begin
    stateNext = state;
    case (state)
      DESYNC: if (accept && s_data == SyncWord) stateNext = ADDR;
      ADDR: begin
        if (accept) begin
          if (s_data == SyncWord)          stateNext = ADDR;
          else if (s_data[31:28] == 4'hF)  stateNext = DESYNC;
          else                             stateNext = DATA;
        end
      end
      DATA:    if (accept && lastRow) stateNext = SETUP;
      SETUP:   stateNext = STROBE;
      STROBE:  stateNext = HOLD;
      HOLD:    stateNext = ADDR;
      default: stateNext = DESYNC;
    endcase
  end

  // Strobe is registered on the SETUP->STROBE edge so it is high exactly
  // while the state register reads STROBE.
  always_comb begin
    strobeNext = '0;
    for (int i = 0; i < NumStrobes; i++)
      strobeNext[i] = (state == SETUP) && inRange &&
                      (i == int'(colQ) * MaxFramesPerCol + int'(frameQ));
  end

  always_comb begin
    rowWe = '0;
    for (int r = 0; r < NumberOfRows; r++)
      rowWe[r] = (state == DATA) && accept && (int'(rowCnt) == r);
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      s_ready        <= 1'b0;
      rowCnt         <= '0;
      colQ           <= '0;
      frameQ         <= '0;
      FrameStrobe    <= '0;
      error          <= 1'b0;
      frames_written <= '0;
    end else begin
      // Ready is registered from the next state so it is low during reset
      // and through SETUP/STROBE/HOLD.
      s_ready     <= (stateNext == DESYNC) || (stateNext == ADDR) || (stateNext == DATA);
      FrameStrobe <= strobeNext;
      if (state == ADDR && stateNext == DATA) begin
        colQ   <= s_data[23:16];
        frameQ <= s_data[7:0];
        rowCnt <= '0;
      end else if (state == DATA && accept) begin
        rowCnt <= lastRow ? '0 : rowCnt + 1'b1;
      end
      if (state == SETUP) begin
        if (inRange) begin
          if (frames_written != 16'hFFFF) frames_written <= frames_written + 16'd1;
        end else begin
          error <= 1'b1;
        end
      end
    end
  end

  for (genvar r = 0; r < NumberOfRows; r++) begin : gRow
    config_frame_row #(.Width(FrameBitsPerRow)) uRow (
      .CLK     (CLK),
      .resetn  (resetn),
      .wrEn    (rowWe[r]),
      .wrData  (s_data[FrameBitsPerRow-1:0]),
      .rowData (FrameData[r*FrameBitsPerRow +: FrameBitsPerRow])
    );
  end
endmodule

// File: tb/tb_config_frame_sequencer.sv
`timescale 1ns/1ps
module tb_config_frame_sequencer;
  localparam int Rows = 4, Cols = 4, Frames = 20, NS = Cols * Frames;
  localparam logic [31:0] Sync = 32'hFAB0_FAB1;

  logic               CLK = 1'b0, resetn = 1'b0, s_valid = 1'b0;
  logic [31:0]        s_data = '0;
  logic               s_ready, synced, error;
  logic [Rows*32-1:0] FrameData;
  logic [NS-1:0]      FrameStrobe;
  logic [15:0]        frames_written;

  config_frame_sequencer #(.NumberOfRows(Rows), .NumberOfCols(Cols),
    .MaxFramesPerCol(Frames), .FrameBitsPerRow(32), .SyncWord(Sync)) dut (
    .CLK(CLK), .resetn(resetn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .FrameData(FrameData), .FrameStrobe(FrameStrobe), .synced(synced), .error(error),
    .frames_written(frames_written));

  always #5 CLK = ~CLK;

  longint cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0, bad = 0;

  // Word-level reference model: what each accepted word means to the stream.
  bit          mSynced, mErr;
  int          mRowsLeft, mCol, mFrame, mFrames, expIdx;
  logic [31:0] mData [Rows];
  longint      lastDataCyc, expStrobeCyc;
  bit          monOn = 1'b0;
  int          strobePulses = 0;
  logic [NS-1:0] strobeOr = '0;

  task automatic modelReset();
    mSynced = 0; mErr = 0; mRowsLeft = 0; mCol = 0; mFrame = 0; mFrames = 0; expIdx = 0;
    for (int r = 0; r < Rows; r++) mData[r] = '0;
    lastDataCyc = -100; expStrobeCyc = -100;
  endtask

  task automatic modelAccept(input logic [31:0] w, input longint at);
    if (!mSynced) begin
      if (w == Sync) mSynced = 1;
    end else if (mRowsLeft == 0) begin
      if (w != Sync && w[31:28] == 4'hF) mSynced = 0;
      else if (w != Sync) begin
        mCol = int'(w[23:16]); mFrame = int'(w[7:0]); mRowsLeft = Rows;
      end
    end else begin
      mData[Rows - mRowsLeft] = w;
      mRowsLeft--;
      if (mRowsLeft == 0) begin
        lastDataCyc = at;
        if (mCol < Cols && mFrame < Frames) begin
          expStrobeCyc = at + 2; expIdx = mCol * Frames + mFrame;
          if (mFrames < 65535) mFrames++;
        end else mErr = 1;
      end
    end
  endtask

  // Cycle monitor: strobe timing/position, data stability, ready and sync.
  always @(negedge CLK) begin : mon
    logic [NS-1:0]      expS;
    logic [Rows*32-1:0] expD;
    logic               expR;
    if (monOn) begin
      expS = '0;
      if (cyc == expStrobeCyc) expS[expIdx] = 1'b1;
      for (int r = 0; r < Rows; r++) expD[r*32 +: 32] = mData[r];
      expR = !(cyc >= lastDataCyc + 1 && cyc <= lastDataCyc + 3);
      total += 4;
      if (FrameStrobe !== expS) begin bad++; $display("FAIL mon_strobe cyc=%0d got=%h exp=%h", cyc, FrameStrobe, expS); end
      if (FrameData !== expD) begin bad++; $display("FAIL mon_data cyc=%0d got=%h exp=%h", cyc, FrameData, expD); end
      if (s_ready !== expR) begin bad++; $display("FAIL mon_ready cyc=%0d got=%b exp=%b", cyc, s_ready, expR); end
      if (synced !== mSynced) begin bad++; $display("FAIL mon_synced cyc=%0d got=%b exp=%b", cyc, synced, mSynced); end
      if (FrameStrobe != '0) strobePulses++;
      strobeOr = strobeOr | FrameStrobe;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Called at a negedge; returns at the negedge after acceptance with s_valid low.
  task automatic sendWord(input logic [31:0] w, input int gap);
    int n = 0;
    repeat (gap) @(negedge CLK);
    s_valid = 1'b1; s_data = w;
    forever begin
      @(posedge CLK);
      if (s_ready) begin modelAccept(w, cyc); break; end
      n++;
      if (n > 20) begin total++; bad++; $display("FAIL handshake_timeout word=%h", w); break; end
    end
    @(negedge CLK);
    s_valid = 1'b0;
  endtask

  task automatic sendFrame(input logic [31:0] addr, input logic [Rows-1:0][31:0] d, input int gap);
    sendWord(addr, gap);
    for (int r = 0; r < Rows; r++) sendWord(d[r], gap);
  endtask

  task automatic test_reset();
    modelReset();
    #12;
    total += 6;
    if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", s_ready); end
    if (FrameStrobe !== '0) begin bad++; $display("FAIL rst_strobe got=%h exp=0", FrameStrobe); end
    if (FrameData !== '0) begin bad++; $display("FAIL rst_data got=%h exp=0", FrameData); end
    if (synced !== 1'b0) begin bad++; $display("FAIL rst_synced got=%b exp=0", synced); end
    if (error !== 1'b0) begin bad++; $display("FAIL rst_error got=%b exp=0", error); end
    if (frames_written !== 16'd0) begin bad++; $display("FAIL rst_frames got=%0d exp=0", frames_written); end
    @(negedge CLK) resetn = 1'b1;
    idle(2);
    total += 2;
    if (s_ready !== 1'b1) begin bad++; $display("FAIL rel_ready got=%b exp=1", s_ready); end
    if (synced !== 1'b0) begin bad++; $display("FAIL rel_synced got=%b exp=0", synced); end
    monOn = 1'b1;
  endtask

  task automatic test_sync();
    sendWord(32'h1234_5678, 0);
    total++;
    if (synced !== 1'b0) begin bad++; $display("FAIL sync_garbage got=%b exp=0", synced); end
    sendWord(Sync, 1);
    total++;
    if (synced !== 1'b1) begin bad++; $display("FAIL sync_word got=%b exp=1", synced); end
    idle(2);
    total++;
    if (strobeOr !== '0) begin bad++; $display("FAIL sync_nostrobe got=%h exp=0", strobeOr); end
  endtask

  task automatic test_single_frame();
    logic [Rows-1:0][31:0] d;
    logic [NS-1:0] seen, expS;
    int hiCnt = 0, hiAt = -1, lowReady = 0;
    d = {$urandom, $urandom, $urandom, $urandom};
    seen = '0; expS = '0; expS[45] = 1'b1;
    sendFrame(32'h0002_0005, d, 0);
    for (int k = 1; k <= 6; k++) begin
      if (FrameStrobe != '0) begin hiCnt++; hiAt = k; seen = FrameStrobe; end
      if (!s_ready) lowReady++;
      if (k < 6) @(negedge CLK);
    end
    total += 6;
    if (hiCnt != 1) begin bad++; $display("FAIL single_strobe_len got=%0d exp=1", hiCnt); end
    if (hiAt != 2) begin bad++; $display("FAIL single_strobe_lat got=%0d exp=2", hiAt); end
    if (seen !== expS) begin bad++; $display("FAIL single_strobe_bit got=%h exp=%h", seen, expS); end
    if (lowReady != 3) begin bad++; $display("FAIL single_ready_low got=%0d exp=3", lowReady); end
    if (FrameData !== d) begin bad++; $display("FAIL single_data got=%h exp=%h", FrameData, d); end
    if (frames_written !== 16'd1) begin bad++; $display("FAIL single_frames got=%0d exp=1", frames_written); end
  endtask

  task automatic test_back_to_back();
    logic [Rows-1:0][31:0] d0, d1;
    logic [NS-1:0] expS;
    int p0;
    d0 = {$urandom, $urandom, $urandom, $urandom};
    d1 = {Sync, 32'hF000_0000, $urandom, $urandom};
    expS = '0; expS[0] = 1'b1; expS[79] = 1'b1;
    strobeOr = '0; p0 = strobePulses;
    sendFrame(32'h0000_0000, d0, 0);
    sendFrame(32'h0003_0013, d1, 0);
    idle(5);
    total += 4;
    if (strobeOr !== expS) begin bad++; $display("FAIL b2b_bits got=%h exp=%h", strobeOr, expS); end
    if (strobePulses - p0 != 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", strobePulses - p0); end
    if (frames_written !== 16'd3) begin bad++; $display("FAIL b2b_frames got=%0d exp=3", frames_written); end
    if (FrameData !== d1) begin bad++; $display("FAIL b2b_data got=%h exp=%h", FrameData, d1); end
  endtask

  task automatic test_out_of_range();
    logic [Rows-1:0][31:0] d0, d1;
    d0 = {$urandom, $urandom, $urandom, $urandom};
    d1 = {$urandom, $urandom, $urandom, $urandom};
    strobeOr = '0;
    sendFrame(32'h0004_0000, d0, 1);
    sendFrame(32'h0000_0014, d1, 0);
    idle(5);
    total += 4;
    if (strobeOr !== '0) begin bad++; $display("FAIL oor_strobe got=%h exp=0", strobeOr); end
    if (error !== 1'b1) begin bad++; $display("FAIL oor_error got=%b exp=1", error); end
    if (frames_written !== 16'd3) begin bad++; $display("FAIL oor_frames got=%0d exp=3", frames_written); end
    if (FrameData !== d1) begin bad++; $display("FAIL oor_data got=%h exp=%h", FrameData, d1); end
  endtask

  task automatic test_desync();
    logic [Rows-1:0][31:0] d;
    logic [NS-1:0] expS;
    strobeOr = '0;
    sendWord(32'hF000_0000, 0);
    total++;
    if (synced !== 1'b0) begin bad++; $display("FAIL desync_synced got=%b exp=0", synced); end
    d = {$urandom, $urandom, $urandom, $urandom};
    sendFrame(32'h0001_0001, d, 0);
    idle(4);
    total += 2;
    if (strobeOr !== '0) begin bad++; $display("FAIL desync_ignored got=%h exp=0", strobeOr); end
    if (frames_written !== 16'd3) begin bad++; $display("FAIL desync_frames got=%0d exp=3", frames_written); end
    sendWord(Sync, 0);
    sendWord(Sync, 0);  // repeated sync in ADDR is ignored
    d = {32'h0BAD_CAFE, $urandom, Sync, 32'hF000_0000};
    sendFrame(32'h0001_0001, d, 0);
    idle(5);
    expS = '0; expS[21] = 1'b1;
    total += 4;
    if (FrameData[31:0] !== 32'hF000_0000) begin bad++; $display("FAIL desync_in_data got=%h exp=f0000000", FrameData[31:0]); end
    if (FrameData[63:32] !== Sync) begin bad++; $display("FAIL sync_in_data got=%h exp=%h", FrameData[63:32], Sync); end
    if (strobeOr !== expS) begin bad++; $display("FAIL resync_strobe got=%h exp=%h", strobeOr, expS); end
    if (frames_written !== 16'd4) begin bad++; $display("FAIL resync_frames got=%0d exp=4", frames_written); end
  endtask

  task automatic test_random();
    logic [Rows-1:0][31:0] d;
    logic [31:0] a, w;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        w = {4'hF, 28'($urandom)};
        if (w == Sync) w = 32'hF000_0001;
        sendWord(w, $urandom_range(0, 2));
        if ($urandom_range(0, 1) == 1) sendWord(Sync, $urandom_range(0, 2));
      end else begin
        a = {4'($urandom_range(0, 14)), 4'($urandom), 8'($urandom_range(0, 5)),
             8'($urandom), 8'($urandom_range(0, 23))};
        d = {$urandom, $urandom, $urandom, $urandom};
        sendFrame(a, d, $urandom_range(0, 2));
      end
    end
    idle(5);
    total += 2;
    if (frames_written !== 16'(mFrames)) begin bad++; $display("FAIL rand_frames got=%0d exp=%0d", frames_written, mFrames); end
    if (error !== mErr) begin bad++; $display("FAIL rand_error got=%b exp=%b", error, mErr); end
  endtask

  task automatic test_reset_mid_strobe();
    logic [Rows-1:0][31:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    sendWord(Sync, 0);
    sendFrame(32'h0001_0002, d, 0);
    @(negedge CLK);  // strobe cycle
    total++;
    if (FrameStrobe[22] !== 1'b1) begin bad++; $display("FAIL mid_strobe_high got=%h", FrameStrobe); end
    #1 resetn = 1'b0; monOn = 1'b0;
    #1;
    total += 6;
    if (FrameStrobe !== '0) begin bad++; $display("FAIL mid_strobe_drop got=%h exp=0", FrameStrobe); end
    if (s_ready !== 1'b0) begin bad++; $display("FAIL mid_ready got=%b exp=0", s_ready); end
    if (FrameData !== '0) begin bad++; $display("FAIL mid_data got=%h exp=0", FrameData); end
    if (error !== 1'b0) begin bad++; $display("FAIL mid_error got=%b exp=0", error); end
    if (frames_written !== 16'd0) begin bad++; $display("FAIL mid_frames got=%0d exp=0", frames_written); end
    if (synced !== 1'b0) begin bad++; $display("FAIL mid_synced got=%b exp=0", synced); end
    @(negedge CLK) resetn = 1'b1;
    modelReset();
    idle(2);
    monOn = 1'b1;
    strobeOr = '0;
    sendFrame(32'h0001_0002, d, 0);  // not synced: discarded
    idle(4);
    total += 2;
    if (strobeOr !== '0) begin bad++; $display("FAIL post_rst_strobe got=%h exp=0", strobeOr); end
    if (synced !== 1'b0) begin bad++; $display("FAIL post_rst_synced got=%b exp=0", synced); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sync();
    test_single_frame();
    test_back_to_back();
    test_out_of_range();
    test_desync();
    test_random();
    test_reset_mid_strobe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
